// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Requester port indices
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Default cycles allowed in ACCESS without mem_ready before abort
  localparam int DEFAULT_TIMEOUT = 16;

  // Round-robin pick: on a tie the port that did not win last time goes.
  // Only meaningful when at least one request is high.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    if (req0 && req1) return ~last;
    else if (req1)    return PORT_DMA;
    else              return PORT_CPU;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single unified instruction/data memory port.
// Port 0 is the CPU fetch/load/store path, port 1 the loader / debug DMA.
//
// Handshake: a requester raises rN_req with stable we/addr/wdata and holds it
// until rN_ack; rN_ack is a one-cycle completion pulse, with rN_rdata and err
// valid in that same cycle. On the memory side mem_en is held for the whole
// access with address/control stable, and the access completes on the first
// edge where mem_ready is high (which may be the first mem_en cycle).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT  // must be >= 2
) (
  input  logic          clk,
  input  logic          reset,
  // port 0 (CPU)
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  // port 1 (loader / DMA)
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  // status
  output logic          err,
  output logic          busy,
  output arb_state_e    dbg_state,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state;
  logic          last_grant;
  logic          sel;
  logic [CW-1:0] cnt;
  logic          pick;

  // Port chosen if a grant happens this cycle
  always_comb begin
    pick = rr_pick(r0_req, r1_req, last_grant);
  end

  // Arbiter FSM: grant, wait on mem_ready or timeout, one-cycle response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_DMA;
      sel        <= PORT_CPU;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            sel        <= pick;
            last_grant <= pick;
            cnt        <= '0;
            mem_we     <= pick ? r1_we    : r0_we;
            mem_addr   <= pick ? r1_addr  : r0_addr;
            mem_wdata  <= pick ? r1_wdata : r0_wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            // Writes leave the read-data register untouched
            if (!mem_we) begin
              if (sel) r1_rdata <= mem_rdata;
              else     r0_rdata <= mem_rdata;
            end
            err    <= 1'b0;
            r0_ack <= (sel == PORT_CPU);
            r1_ack <= (sel == PORT_DMA);
            state  <= RESP;
          end else if (cnt == CNT_LAST) begin
            // Timed out: return zero data and flag the error with the ack
            if (sel) r1_rdata <= '0;
            else     r0_rdata <= '0;
            err    <= 1'b1;
            r0_ack <= (sel == PORT_CPU);
            r1_ack <= (sel == PORT_DMA);
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // No grant here, so a request still high during its ack is not re-granted
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          err    <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from state so they drop immediately on reset
  always_comb begin
    mem_en    = (state == ACCESS);
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Protocol invariants
  a_ack_onehot : assert property (@(posedge clk) disable iff (reset)
    !(r0_ack && r1_ack));
  a_err_with_ack : assert property (@(posedge clk) disable iff (reset)
    err |-> (r0_ack || r1_ack));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters.
- Port 0 is the multicycle CPU controller's fetch/load/store path. Port 1 is the program loader / debug DMA.
- A registered FSM grants one requester per access, waits on the memory's ready handshake, and bounds each access with a timeout.
- Sits between the requesters and the memory model; the CPU stalls in its state while ack0 is low.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- TIMEOUT, 16, maximum cycles in ACCESS without mem_ready before abort (must be >= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 access request; held high until r0_ack
- r0_we  in  1  port 0 write enable (1 = write, 0 = read)
- r0_addr  in  AW  port 0 address
- r0_wdata  in  DW  port 0 write data
- r0_ack  out  1  port 0 completion pulse, one cycle wide
- r0_rdata  out  DW  port 0 read data; valid while r0_ack is high
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata  same as port 0, for port 1
- err  out  1  high together with the ack pulse when the access timed out
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid when mem_ready is high
- mem_ready  in  1  memory completion; may be high in the first mem_en cycle
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous):
  - state = IDLE, last_grant = 1, cnt = 0.
  - All outputs are 0, and both rdata registers are 0.
- States: IDLE, ACCESS, RESP. Everything is registered. Only mem_en and busy are decoded from state.
- IDLE:
  - On a clock edge, sample r0_req and r1_req.
  - Neither high: stay in IDLE.
  - Exactly one high: grant that port.
  - Both high: grant the port other than last_grant (round-robin), so port 0 wins the first tie after reset.
  - On grant: latch the granted port's addr, we and wdata into mem_addr, mem_we and mem_wdata. Set sel = granted port, update last_grant, set cnt = 0, go to ACCESS.
- ACCESS:
  - mem_en = 1. mem_addr, mem_we and mem_wdata are held stable from the latched values.
  - Requester inputs are ignored, including changes on the granted port.
  - Edge with mem_ready = 1: capture mem_rdata into rdata[sel] if the access is a read (writes leave rdata[sel] unchanged). Set err_next = 0 and go to RESP.
  - Edge with mem_ready = 0 and cnt == TIMEOUT-1: rdata[sel] = 0, err_next = 1, go to RESP.
  - Otherwise: cnt increments by 1.
- RESP:
  - Exactly one cycle. r{sel}_ack = 1 and err = err_next. mem_en = 0.
  - Next state is always IDLE. No grant is made in RESP, so a req still high during the ack cycle is not re-granted.
  - After RESP, a req still high in IDLE is treated as a new access.
- Latency: request sampled at edge E, mem_ready in the first ACCESS cycle, ack high in cycle E+2, IDLE in cycle E+3.
- Both requesters continuously requesting: grants strictly alternate 0, 1, 0, 1, ...
- A request dropped before its grant is legal; no access is made.
- A request dropped during ACCESS: the access still completes and the ack is still issued.
- mem_ready outside ACCESS is ignored.
- r0_ack and r1_ack are never high in the same cycle. err is 0 whenever both acks are 0.
- Reset mid-ACCESS: the access is abandoned at once, mem_en drops asynchronously, and no ack is issued.
- cnt width is clog2(TIMEOUT). cnt never wraps, because it is cleared on every grant.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - port index constants PORT_CPU = 0 and PORT_DMA = 1;
  - the default TIMEOUT constant.
- Single module. The round-robin pick is a few lines, so no sub-module is needed.

Test Plan:
- Single read: r0_req, r0_addr = 0x40, memory ready in the first ACCESS cycle with mem_rdata = 0xDEADBEEF -> mem_en high for exactly 1 cycle, r0_ack in cycle E+2, r0_rdata = 0xDEADBEEF, err = 0.
- Write with 3 wait cycles: r1_req, r1_we = 1, r1_addr = 0x80, r1_wdata = 0x12345678 -> mem_we = 1 and mem_addr/mem_wdata stable for 4 cycles, r1_ack once, r1_rdata unchanged.
- Contention: r0_req and r1_req both held high for 4 transactions from reset -> grant order 0, 1, 0, 1; no cycle has both acks high.
- Timeout: r0_req read, mem_ready tied low, TIMEOUT = 16 -> mem_en high for 16 cycles, then r0_ack = 1, err = 1, r0_rdata = 0.
- Back-to-back: r0_req held high through its ack -> second access starts with mem_en 2 cycles after the first ack; exactly 2 acks in total.
- Reset mid-ACCESS: assert reset asynchronously in cycle 2 of a wait-state access -> mem_en and busy drop without waiting for a clock edge, no ack, and port 0 wins the next tie.
